// File: rtl/conv_pkg.sv
// Shared definitions for the 3x3 convolution MAC sequencer: FSM encoding,
// default geometry and the output clip bounds used when CONV3X3_CLIP_EN is defined.
package conv_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } conv_state_t;

    localparam int TAPS_DEF   = 9;
    localparam int DATA_W_DEF = 8;
    localparam int ACC_W_DEF  = 20;

    localparam int CLIP_LO = 0;
    localparam int CLIP_HI = 255;

endpackage

// File: rtl/conv3x3_mac_seq.sv
// Sequences one 3x3 window through an external multiplier, accumulating tap products.
// Define CONV3X3_CLIP_EN to clamp the result to [CLIP_LO, CLIP_HI]; otherwise the raw sum is output.
module conv3x3_mac_seq
    import conv_pkg::*;
#(
    parameter int TAPS   = TAPS_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int ACC_W  = ACC_W_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [TAPS*DATA_W-1:0]     pix_flat,
    input  logic [TAPS*DATA_W-1:0]     coef_flat,
    output logic                       mul_start,
    output logic signed [DATA_W-1:0]   mul_x,
    output logic signed [DATA_W-1:0]   mul_y,
    input  logic                       mul_valid,
    input  logic signed [2*DATA_W-1:0] mul_z,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic signed [ACC_W-1:0]    out_data,
    output logic                       busy,
    output conv_state_t                dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
    // valid, once raised, holds with its payload stable until that edge.

    localparam int TAP_W = (TAPS > 1) ? $clog2(TAPS) : 1;
    localparam logic [TAP_W-1:0] LAST_TAP = TAP_W'(TAPS - 1);

    conv_state_t                state;
    logic [TAPS*DATA_W-1:0]     pix_r;
    logic [TAPS*DATA_W-1:0]     coef_r;
    logic signed [ACC_W-1:0]    acc;
    logic signed [ACC_W-1:0]    acc_next;
    logic signed [ACC_W-1:0]    result;
    logic [TAP_W-1:0]           tap;
    logic [TAP_W-1:0]           tap_inc;

    assign acc_next  = acc + ACC_W'(mul_z);
    assign tap_inc   = tap + TAP_W'(1);
    assign in_ready  = (state == S_IDLE);
    assign busy      = (state != S_IDLE);
    assign dbg_state = state;

`ifdef CONV3X3_CLIP_EN
    localparam logic signed [ACC_W-1:0] LO = ACC_W'(CLIP_LO);
    localparam logic signed [ACC_W-1:0] HI = ACC_W'(CLIP_HI);

    always_comb begin
        result = acc_next;
        if (acc_next < LO)
            result = LO;
        else if (acc_next > HI)
            result = HI;
    end
`else
    assign result = acc_next;
`endif

    // Operands are loaded on the edge entering ISSUE and held until the next tap is loaded,
    // so they stay valid through the cycle in which mul_valid is sampled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            pix_r     <= '0;
            coef_r    <= '0;
            acc       <= '0;
            tap       <= '0;
            mul_start <= 1'b0;
            mul_x     <= '0;
            mul_y     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        pix_r     <= pix_flat;
                        coef_r    <= coef_flat;
                        acc       <= '0;
                        tap       <= '0;
                        mul_x     <= pix_flat[0 +: DATA_W];
                        mul_y     <= coef_flat[0 +: DATA_W];
                        mul_start <= 1'b1;
                        state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    mul_start <= 1'b0;
                    state     <= S_WAIT;
                end
                S_WAIT: begin
                    if (mul_valid) begin
                        acc <= acc_next;
                        if (tap == LAST_TAP) begin
                            out_data  <= result;
                            out_valid <= 1'b1;
                            state     <= S_DONE;
                        end else begin
                            tap       <= tap_inc;
                            mul_x     <= pix_r[int'(tap_inc)*DATA_W +: DATA_W];
                            mul_y     <= coef_r[int'(tap_inc)*DATA_W +: DATA_W];
                            mul_start <= 1'b1;
                            state     <= S_ISSUE;
                        end
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_conv3x3_mac_seq.sv
// Bench for conv3x3_mac_seq: randomized windows through a latency-randomized multiplier model,
// scoreboarded against a sum-of-products reference (clamped when CONV3X3_CLIP_EN is defined).
module tb_conv3x3_mac_seq;
    import conv_pkg::*;

    localparam int TAPS = TAPS_DEF;
    localparam int DW   = DATA_W_DEF;
    localparam int AW   = ACC_W_DEF;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic in_valid = 1'b0;
    logic out_ready = 1'b0;
    logic mul_valid_m = 1'b0;
    logic spur_v = 1'b0;
    logic mul_valid;
    logic [TAPS*DW-1:0] pix_flat = '0;
    logic [TAPS*DW-1:0] coef_flat = '0;
    logic in_ready, mul_start, out_valid, busy;
    logic signed [DW-1:0] mul_x, mul_y;
    logic signed [2*DW-1:0] mul_z = '0;
    logic signed [AW-1:0] out_data;
    conv_state_t dbg_state;

    logic [AW-1:0] exp_q[$];
    int exp_px_q[$];
    int exp_cf_q[$];

    int n_cmp = 0;
    int n_err = 0;
    int start_cnt = 0;
    logic hold_mode = 1'b0;

    assign mul_valid = mul_valid_m | spur_v;

    conv3x3_mac_seq #(.TAPS(TAPS), .DATA_W(DW), .ACC_W(AW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .pix_flat(pix_flat), .coef_flat(coef_flat),
        .mul_start(mul_start), .mul_x(mul_x), .mul_y(mul_y),
        .mul_valid(mul_valid), .mul_z(mul_z),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .dbg_state(dbg_state)
    );

    // Clock / watchdog
    always #5 clk = ~clk;

    initial begin
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog: simulation did not complete, got timeout required finish");
        $fatal(1);
    end

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d required %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: got timeout required completion (t=%0t)", name, $time);
    endtask

    // Reference model: plain sum of products, optionally clamped.
    function automatic logic [AW-1:0] ref_result(input int px[TAPS], input int cf[TAPS]);
        int s = 0;
        for (int k = 0; k < TAPS; k++) s += px[k] * cf[k];
`ifdef CONV3X3_CLIP_EN
        if (s < CLIP_LO) s = CLIP_LO;
        if (s > CLIP_HI) s = CLIP_HI;
`endif
        return AW'(s);
    endfunction

    // Driver tasks
    task automatic send_window(input int px[TAPS], input int cf[TAPS]);
        int waited = 0;
        for (int k = 0; k < TAPS; k++) begin
            pix_flat[k*DW +: DW]  = DW'(px[k]);
            coef_flat[k*DW +: DW] = DW'(cf[k]);
        end
        in_valid = 1'b1;
        while (!in_ready && waited < 500) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            timeout_fail("accept");
            in_valid = 1'b0;
            return;
        end
        exp_q.push_back(ref_result(px, cf));
        for (int k = 0; k < TAPS; k++) begin
            exp_px_q.push_back(px[k]);
            exp_cf_q.push_back(cf[k]);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send_const(input int p, input int c);
        int px[TAPS];
        int cf[TAPS];
        for (int k = 0; k < TAPS; k++) begin
            px[k] = p;
            cf[k] = c;
        end
        send_window(px, cf);
    endtask

    task automatic send_random(input bit sparse);
        int px[TAPS];
        int cf[TAPS];
        for (int k = 0; k < TAPS; k++) begin
            px[k] = int'($urandom_range(0, 255)) - 128;
            cf[k] = int'($urandom_range(0, 255)) - 128;
            if (sparse && $urandom_range(0, 2) == 0) cf[k] = 0;
        end
        send_window(px, cf);
    endtask

    task automatic wait_idle();
        int waited = 0;
        while ((exp_q.size() != 0 || !in_ready) && waited < 3000) begin
            @(negedge clk);
            waited++;
        end
        if (exp_q.size() != 0 || !in_ready) timeout_fail("wait_idle");
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_in_ready"}, in_ready, 1);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_mul_start"}, mul_start, 0);
        check({tag, "_mul_x"}, mul_x, 0);
        check({tag, "_mul_y"}, mul_y, 0);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_out_data"}, out_data, 0);
        check({tag, "_state"}, dbg_state, S_IDLE);
    endtask

    // Multiplier model: random latency, product computed from the operands seen at start.
    int m_cnt = 0;
    bit m_busy = 1'b0;
    logic signed [DW-1:0] m_x, m_y;

    always @(negedge clk) begin
        mul_valid_m = 1'b0;
        if (!rst) begin
            m_busy = 1'b0;
        end else if (m_busy) begin
            check("operand_hold_x", mul_x, m_x);
            check("operand_hold_y", mul_y, m_y);
            if (m_cnt == 0) begin
                mul_valid_m = 1'b1;
                mul_z = m_x * m_y;
                m_busy = 1'b0;
            end else begin
                m_cnt--;
            end
        end else if (mul_start) begin
            m_x = mul_x;
            m_y = mul_y;
            m_cnt = $urandom_range(1, 4);
            m_busy = 1'b1;
        end
    end

    // Monitor / scoreboard
    always @(negedge clk) begin
        logic signed [AW-1:0] e;
        if (!rst) begin
            start_cnt = 0;
        end else begin
            if (mul_start) begin
                start_cnt++;
                if (exp_px_q.size() == 0) begin
                    timeout_fail("unexpected_mul_start");
                end else begin
                    check("tap_pixel", mul_x, exp_px_q.pop_front());
                    check("tap_coef", mul_y, exp_cf_q.pop_front());
                end
            end
            out_ready = hold_mode ? 1'b0 : ($urandom_range(0, 3) != 0);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    timeout_fail("unexpected_out_valid");
                end else begin
                    e = exp_q.pop_front();
                    check("out_data", out_data, e);
                    check("mul_start_pulses", start_cnt, TAPS);
                end
                start_cnt = 0;
            end
        end
    end

    // Main stimulus
    initial begin
        int waited;
        logic signed [AW-1:0] held;

        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rst = 1'b1;
        @(negedge clk);
        check("post_reset_in_ready", in_ready, 1);

        send_const(1, 1);
        wait_idle();
        send_const(-128, -128);
        wait_idle();
        send_const(10, -1);
        wait_idle();

        // Result held while downstream stalls.
        hold_mode = 1'b1;
        send_const(3, 7);
        waited = 0;
        while (!out_valid && waited < 500) begin
            @(negedge clk);
            waited++;
        end
        if (!out_valid) timeout_fail("hold_out_valid");
        held = out_data;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_out_valid", out_valid, 1);
            check("hold_out_data", out_data, held);
            check("hold_in_ready", in_ready, 0);
            check("hold_mul_start", mul_start, 0);
        end
        hold_mode = 1'b0;
        wait_idle();

        // Reset while tap 4 is in flight.
        send_random(1'b0);
        waited = 0;
        while (start_cnt < 5 && waited < 500) begin
            @(negedge clk);
            waited++;
        end
        if (start_cnt < 5) timeout_fail("reach_tap4");
        rst = 1'b0;
        exp_q.delete();
        exp_px_q.delete();
        exp_cf_q.delete();
        #1;
        check_reset_values("midreset");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        send_const(2, 3);
        wait_idle();

        // Stray multiplier strobe while idle must not disturb the next window.
        spur_v = 1'b1;
        @(negedge clk);
        spur_v = 1'b0;
        check("spurious_busy", busy, 0);
        check("spurious_state", dbg_state, S_IDLE);
        send_const(-5, 4);
        wait_idle();

        for (int n = 0; n < 40; n++) begin
            send_random(n[0]);
            if ($urandom_range(0, 3) == 0) wait_idle();
        end
        wait_idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
